// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data, shared-memory and owner signals of the memory arbiter
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic                  if_ready_o;
    logic                  dm_req_i;
    logic                  dm_we_i;
    logic                  dm_byte_i;
    logic [ADDR_WIDTH-1:0] dm_addr_i;
    logic [DATA_WIDTH-1:0] dm_wdata_i;
    logic [DATA_WIDTH-1:0] dm_rdata_o;
    logic                  dm_ready_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic                  mem_byte_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;
    logic [1:0]            owner_o;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_byte_i, dm_addr_i, dm_wdata_i,
               mem_rdata_i, mem_ack_i,
        output if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o, mem_req_o, mem_we_o,
               mem_byte_o, mem_addr_o, mem_wdata_o, owner_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_byte_i, dm_addr_i, dm_wdata_i,
               mem_rdata_i, mem_ack_i,
        input  if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o, mem_req_o, mem_we_o,
               mem_byte_o, mem_addr_o, mem_wdata_o, owner_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data, data first with a fetch starvation guard
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst_i,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, GNT_IF = 2'b01, GNT_DM = 2'b10} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_byte_q, mem_byte_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  dm_ready_q, dm_ready_d;
    logic                  if_elig, dm_elig, pick_dm;

    // a requester in its ready cycle is masked so its finished request is not granted twice
    always_comb begin
        if_elig = bus.if_req_i && !if_ready_q;
        dm_elig = bus.dm_req_i && !dm_ready_q;
        pick_dm = dm_elig && !(if_elig && starve_q == LIMIT);
    end

    // grant decision, command latch at grant, completion capture and starvation bookkeeping
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_byte_d  = mem_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_dm) begin
                    state_d     = GNT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we_i;
                    mem_byte_d  = bus.dm_byte_i;
                    mem_addr_d  = bus.dm_addr_i;
                    mem_wdata_d = bus.dm_wdata_i;
                    starve_d    = !bus.if_req_i ? 4'd0 : (starve_q >= LIMIT ? LIMIT : starve_q + 4'd1);
                end else if (if_elig) begin
                    state_d     = GNT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_byte_d  = 1'b0;
                    mem_addr_d  = bus.if_addr_i;
                    mem_wdata_d = '0;
                    starve_d    = 4'd0;
                end
            end
            GNT_IF: begin
                if (bus.mem_ack_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = bus.mem_rdata_i;
                end
            end
            GNT_DM: begin
                if (bus.mem_ack_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_ready_d = 1'b1;
                    dm_rdata_d = mem_we_q ? dm_rdata_q : bus.mem_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // all state and outputs are registered; reset abandons any in-flight transaction at once
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_byte_q  <= mem_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign bus.owner_o     = state_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_byte_o  = mem_byte_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.dm_ready_o  = dm_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_mem_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LIMIT = 4;
    localparam int VW    = 2 + 3 + AW + DW + 2 + DW + DW;

    logic clk = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int          m_owner;
    int          m_starve;
    logic        m_if_ready, m_dm_ready, m_we, m_byte;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

    function automatic logic [VW-1:0] observed();
        return {bus.owner_o, bus.mem_req_o, bus.mem_we_o, bus.mem_byte_o, bus.mem_addr_o,
                bus.mem_wdata_o, bus.if_ready_o, bus.dm_ready_o, bus.if_rdata_o, bus.dm_rdata_o};
    endfunction

    function automatic logic [VW-1:0] expected();
        return {2'(m_owner), m_owner != 0, m_we, m_byte, m_addr, m_wdata,
                m_if_ready, m_dm_ready, m_if_rdata, m_dm_rdata};
    endfunction

    task automatic model_reset();
        m_owner = 0; m_starve = 0; m_if_ready = 0; m_dm_ready = 0; m_we = 0; m_byte = 0;
        m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
    endtask

    // one clock of the arbitration rules: whoever owns the port completes on ack, otherwise pick a requester
    task automatic model_step();
        bit if_ok, dm_ok;
        if (rst_i) begin
            model_reset();
            return;
        end
        if_ok = bus.if_req_i && !m_if_ready;
        dm_ok = bus.dm_req_i && !m_dm_ready;
        m_if_ready = 0;
        m_dm_ready = 0;
        if (m_owner == 0) begin
            if (dm_ok && !(if_ok && m_starve == LIMIT)) begin
                m_owner = 2; m_we = bus.dm_we_i; m_byte = bus.dm_byte_i;
                m_addr = bus.dm_addr_i; m_wdata = bus.dm_wdata_i;
                m_starve = bus.if_req_i ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
            end else if (if_ok) begin
                m_owner = 1; m_we = 0; m_byte = 0; m_addr = bus.if_addr_i; m_wdata = 0;
                m_starve = 0;
            end
        end else if (bus.mem_ack_i) begin
            if (m_owner == 1) begin
                m_if_ready = 1;
                m_if_rdata = bus.mem_rdata_i;
            end else begin
                m_dm_ready = 1;
                if (!m_we) m_dm_rdata = bus.mem_rdata_i;
            end
            m_owner = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_byte_i = 0;
        bus.dm_addr_i = 0; bus.dm_wdata_i = 0; bus.mem_rdata_i = 0; bus.mem_ack_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", observed());
        end
        rst_i = 0;
    endtask

    task automatic test_reset_mid();
        bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h80;
        tick();
        checks++;
        if ({bus.owner_o, bus.mem_req_o} !== 3'b101) begin
            failures++;
            $display("FAIL rst_mid_grant got=%b want=101", {bus.owner_o, bus.mem_req_o});
        end
        #3;
        rst_i = 1;
        model_reset();
        #1;
        checks++;
        if ({bus.mem_req_o, bus.owner_o, bus.if_ready_o, bus.dm_ready_o} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_abandon got=%b want=00000",
                     {bus.mem_req_o, bus.owner_o, bus.if_ready_o, bus.dm_ready_o});
        end
        @(posedge clk);
        #1;
        rst_i = 0;
        tick();
        checks++;
        if ({bus.owner_o, bus.mem_req_o, bus.mem_addr_o} !== {2'b10, 1'b1, 32'h80}) begin
            failures++;
            $display("FAIL rst_mid_regrant got=%b/%b/%h want=10/1/00000080",
                     bus.owner_o, bus.mem_req_o, bus.mem_addr_o);
        end
        bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h1111_1111;
        tick();
        checks++;
        if ({bus.dm_ready_o, bus.dm_rdata_o} !== {1'b1, 32'h1111_1111}) begin
            failures++;
            $display("FAIL rst_mid_complete got=%b/%h want=1/11111111", bus.dm_ready_o, bus.dm_rdata_o);
        end
        bus.dm_req_i = 0; bus.mem_ack_i = 0;
        tick();
    endtask

    task automatic test_lone_fetch();
        bus.if_req_i = 1; bus.if_addr_i = 32'h40;
        tick();
        checks++;
        if ({bus.owner_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.if_ready_o} !==
            {2'b01, 1'b1, 1'b0, 32'h40, 1'b0}) begin
            failures++;
            $display("FAIL fetch_grant got=%b/%b/%b/%h/%b want=01/1/0/00000040/0", bus.owner_o,
                     bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.if_ready_o);
        end
        bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({bus.if_ready_o, bus.if_rdata_o, bus.owner_o, bus.mem_req_o} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL fetch_ready got=%b/%h/%b want=1/deadbeef/00", bus.if_ready_o, bus.if_rdata_o, bus.owner_o);
        end
        bus.mem_ack_i = 0;
        tick();
        checks++;
        if ({bus.owner_o, bus.if_ready_o} !== 3'b000) begin
            failures++;
            $display("FAIL fetch_no_regrant got=%b/%b want=00/0", bus.owner_o, bus.if_ready_o);
        end
        bus.if_req_i = 0;
    endtask

    task automatic test_priority_write();
        bus.if_req_i = 1; bus.if_addr_i = 32'h44;
        bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_byte_i = 0; bus.dm_addr_i = 32'h100;
        bus.dm_wdata_i = 32'h1234_5678;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.owner_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !==
                {2'b10, 1'b1, 1'b1, 32'h100, 32'h1234_5678}) begin
                failures++;
                $display("FAIL prio_wait%0d got=%b/%b/%b/%h/%h want=10/1/1/00000100/12345678", i,
                         bus.owner_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
            end
            if (i < 2) tick();
        end
        bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hBADB_AD00;
        tick();
        checks++;
        if ({bus.dm_ready_o, bus.dm_rdata_o, bus.owner_o} !== {1'b1, 32'h1111_1111, 2'b00}) begin
            failures++;
            $display("FAIL prio_write_done got=%b/%h/%b want=1/11111111/00", bus.dm_ready_o, bus.dm_rdata_o, bus.owner_o);
        end
        bus.dm_req_i = 0; bus.mem_ack_i = 0;
        tick();
        checks++;
        if ({bus.owner_o, bus.mem_we_o, bus.mem_addr_o} !== {2'b01, 1'b0, 32'h44}) begin
            failures++;
            $display("FAIL prio_fetch_next got=%b/%b/%h want=01/0/00000044", bus.owner_o, bus.mem_we_o, bus.mem_addr_o);
        end
        bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h0A0B_0C0D;
        tick();
        checks++;
        if ({bus.if_ready_o, bus.if_rdata_o} !== {1'b1, 32'h0A0B_0C0D}) begin
            failures++;
            $display("FAIL prio_fetch_done got=%b/%h want=1/0a0b0c0d", bus.if_ready_o, bus.if_rdata_o);
        end
        bus.if_req_i = 0; bus.mem_ack_i = 0;
        tick();
    endtask

    task automatic test_starvation();
        for (int r = 0; r < 2; r++) begin
            int grants = 0;
            for (int k = 0; k <= LIMIT; k++) begin
                bus.if_req_i = 1; bus.if_addr_i = 32'h500;
                bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h600 + 32'(k * 4);
                tick();
                checks++;
                if (bus.owner_o !== (k < LIMIT ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL starve_r%0d_k%0d got=%b want=%b", r, k, bus.owner_o, k < LIMIT ? 2'b10 : 2'b01);
                end
                if (bus.owner_o == 2'b10) grants++;
                bus.if_req_i = 0; bus.dm_req_i = 0;
                bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hA000_0000 + 32'(k);
                tick();
                bus.mem_ack_i = 0;
                tick();
            end
            checks++;
            if (grants != LIMIT) begin
                failures++;
                $display("FAIL starve_count_r%0d got=%0d want=%0d", r, grants, LIMIT);
            end
        end
    endtask

    task automatic test_addr_change();
        bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h200;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.owner_o, bus.mem_addr_o, bus.mem_we_o} !== {2'b10, 32'h200, 1'b0}) begin
                failures++;
                $display("FAIL addr_hold%0d got=%b/%h/%b want=10/00000200/0", i, bus.owner_o, bus.mem_addr_o, bus.mem_we_o);
            end
            bus.dm_addr_i = 32'h300; bus.dm_we_i = 1; bus.dm_wdata_i = 32'h5555_5555;
            if (i < 2) tick();
        end
        bus.dm_req_i = 0;
        bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hCAFE_F00D;
        tick();
        checks++;
        if ({bus.dm_ready_o, bus.dm_rdata_o} !== {1'b1, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL addr_done got=%b/%h want=1/cafef00d", bus.dm_ready_o, bus.dm_rdata_o);
        end
        bus.mem_ack_i = 0;
        tick();
    endtask

    task automatic test_spurious_ack();
        bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.owner_o, bus.if_ready_o, bus.dm_ready_o, bus.if_rdata_o, bus.dm_rdata_o} !==
                {2'b00, 1'b0, 1'b0, 32'hA000_0004, 32'hCAFE_F00D}) begin
                failures++;
                $display("FAIL spurious%0d got=%b/%b/%b/%h/%h want=00/0/0/a0000004/cafef00d", i, bus.owner_o,
                         bus.if_ready_o, bus.dm_ready_o, bus.if_rdata_o, bus.dm_rdata_o);
            end
        end
        bus.mem_ack_i = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (bus.if_ready_o && $urandom_range(3) != 0) bus.if_req_i = 0;
            else if (!bus.if_req_i && $urandom_range(2) == 0) begin
                bus.if_req_i = 1; bus.if_addr_i = $urandom;
            end
            if (bus.dm_ready_o && $urandom_range(3) != 0) bus.dm_req_i = 0;
            else if (!bus.dm_req_i && $urandom_range(2) == 0) begin
                bus.dm_req_i = 1; bus.dm_we_i = $urandom_range(1) == 1; bus.dm_byte_i = $urandom_range(1) == 1;
                bus.dm_addr_i = $urandom; bus.dm_wdata_i = $urandom;
            end else if ($urandom_range(7) == 0) begin
                bus.dm_addr_i = $urandom; bus.dm_wdata_i = $urandom; bus.dm_we_i = ~bus.dm_we_i;
            end
            bus.mem_ack_i = $urandom_range(2) == 0;
            bus.mem_rdata_i = $urandom;
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h want=%h", i, observed(), expected());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_lone_fetch();
        test_priority_write();
        test_starvation();
        test_addr_change();
        test_spurious_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
